// File: rtl/pwm_update_sequencer.sv
// PWM update sequencer: tracks dirty LED channels, stages them from the
// register image one per clock and commits on the PWM period boundary.
module pwm_update_sequencer (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic [0:2047] register_blob_i,
    input  logic          write_enable_i,
    input  logic [7:0]    write_register_id_i,
    input  logic [11:0]   counter_i,
    output logic [15:0]   pwm_on_o,
    output logic [15:0]   pwm_off_o,
    output logic [191:0]  pwm_high_o,
    output logic [191:0]  pwm_low_o,
    output logic [7:0]    prescale_o,
    output logic          sleep_o,
    output logic          busy_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        S_ALL  = 2'd1,
        S_CHAN = 2'd2
    } state_t;

    state_t state, state_n;

    logic [15:0]       dirty, dirty_n;
    logic              all_pending, all_pending_n;
    logic              pre_pending, pre_pending_n;
    logic [15:0]       stg_valid, stg_valid_n;
    logic [15:0]       stg_on, stg_off;
    logic [15:0][11:0] stg_high, stg_low;
    logic [11:0]       counter_prev;

    logic       wr_chan, wr_all, wr_pre;
    logic [7:0] wr_rel;
    logic [3:0] wr_idx;
    logic [3:0] low_idx;
    logic [7:0] ch_base;
    logic       wrap, commit;
    logic       do_all, do_chan;

    logic [7:0] mode1;
    logic [7:0] all_on_l, all_on_h, all_off_l, all_off_h;
    logic [7:0] ch_on_l, ch_on_h, ch_off_l, ch_off_h;

    // Byte k of the image has its MSB at the lowest bit index.
    function automatic logic [7:0] blob_byte(input logic [7:0] k);
        return register_blob_i[{k, 3'b000} +: 8];
    endfunction

    // Decode the write strobe into channel / all-LED / prescale events.
    always_comb begin
        wr_rel  = write_register_id_i - 8'd6;
        wr_idx  = wr_rel[5:2];
        wr_chan = write_enable_i
                  && (write_register_id_i >= 8'h06)
                  && (write_register_id_i <= 8'h45);
        wr_all  = write_enable_i
                  && (write_register_id_i >= 8'hFA)
                  && (write_register_id_i <= 8'hFD);
        wr_pre  = write_enable_i && (write_register_id_i == 8'hFE);
    end

    // Pick the lowest-index dirty channel and fetch its register bytes.
    always_comb begin
        low_idx = '0;
        for (int i = 15; i >= 0; i--) begin
            if (dirty[i]) low_idx = 4'(i);
        end
        ch_base   = 8'd6 + {2'b00, low_idx, 2'b00};
        ch_on_l   = blob_byte(ch_base);
        ch_on_h   = blob_byte(ch_base + 8'd1);
        ch_off_l  = blob_byte(ch_base + 8'd2);
        ch_off_h  = blob_byte(ch_base + 8'd3);
        all_on_l  = blob_byte(8'hFA);
        all_on_h  = blob_byte(8'hFB);
        all_off_l = blob_byte(8'hFC);
        all_off_h = blob_byte(8'hFD);
        mode1     = blob_byte(8'h00);
    end

    // Commit on the counter wrap, or every cycle while the counter is frozen.
    always_comb begin
        wrap   = (counter_prev == 12'hFFF) && (counter_i == 12'h000);
        commit = wrap || (sleep_o && (|stg_valid));
    end

    // FSM state register.
    always_ff @(posedge clk_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_n;
    end

    // FSM next state; staging states hold through a commit cycle.
    always_comb begin
        state_n = state;
        case (state)
            IDLE: begin
                if (all_pending)  state_n = S_ALL;
                else if (|dirty)  state_n = S_CHAN;
            end
            S_ALL:   if (!commit) state_n = IDLE;
            S_CHAN:  if (!commit) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // FSM outputs: which staging action fires this cycle.
    always_comb begin
        do_all  = (state == S_ALL) && !commit;
        do_chan = (state == S_CHAN) && !commit && (|dirty);
    end

    // Next values of the tracking masks; a new write beats a same-cycle clear.
    always_comb begin
        dirty_n = dirty;
        if (do_chan) dirty_n[low_idx] = 1'b0;
        if (wr_all)  dirty_n = '0;
        if (wr_chan) dirty_n[wr_idx] = 1'b1;

        all_pending_n = wr_all || (all_pending && !do_all);
        pre_pending_n = wr_pre;

        stg_valid_n = stg_valid;
        if (commit)       stg_valid_n = '0;
        else if (do_all)  stg_valid_n = '1;
        else if (do_chan) stg_valid_n[low_idx] = 1'b1;
    end

    // Control state, sleep tracking and sleep-gated prescale hand-off.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            dirty        <= '0;
            all_pending  <= 1'b0;
            pre_pending  <= 1'b0;
            stg_valid    <= '0;
            busy_o       <= 1'b0;
            counter_prev <= '0;
            sleep_o      <= 1'b1;
            prescale_o   <= 8'h1E;
        end else begin
            dirty        <= dirty_n;
            all_pending  <= all_pending_n;
            pre_pending  <= pre_pending_n;
            stg_valid    <= stg_valid_n;
            busy_o       <= (|dirty_n) | all_pending_n
                            | pre_pending_n | (|stg_valid_n);
            counter_prev <= counter_i;
            sleep_o      <= mode1[4];
            if (pre_pending && mode1[4]) prescale_o <= blob_byte(8'hFE);
        end
    end

    // Staging registers, filled from ALL_LED or from one channel.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stg_on   <= '0;
            stg_off  <= '0;
            stg_high <= '0;
            stg_low  <= '0;
        end else if (do_all) begin
            for (int i = 0; i < 16; i++) begin
                stg_on[i]   <= all_on_h[4];
                stg_off[i]  <= all_off_h[4];
                stg_high[i] <= {all_on_h[3:0], all_on_l};
                stg_low[i]  <= {all_off_h[3:0], all_off_l};
            end
        end else if (do_chan) begin
            stg_on[low_idx]   <= ch_on_h[4];
            stg_off[low_idx]  <= ch_off_h[4];
            stg_high[low_idx] <= {ch_on_h[3:0], ch_on_l};
            stg_low[low_idx]  <= {ch_off_h[3:0], ch_off_l};
        end
    end

    // Driver outputs: copy every staged channel at once on commit.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pwm_on_o   <= '0;
            pwm_off_o  <= 16'hFFFF;
            pwm_high_o <= '0;
            pwm_low_o  <= '0;
        end else if (commit) begin
            for (int i = 0; i < 16; i++) begin
                if (stg_valid[i]) begin
                    pwm_on_o[i]           <= stg_on[i];
                    pwm_off_o[i]          <= stg_off[i];
                    pwm_high_o[12*i +: 12] <= stg_high[i];
                    pwm_low_o[12*i +: 12]  <= stg_low[i];
                end
            end
        end
    end

endmodule

// File: tb/tb_pwm_update_sequencer.sv
// Directed bench for pwm_update_sequencer: emulates register_data writes
// and a PWM counter, then checks committed outputs against hand values.
module tb_pwm_update_sequencer;

    logic          clk = 1'b0;
    logic          rst;
    logic [0:2047] blob;
    logic          we;
    logic [7:0]    id;
    logic [11:0]   cnt;
    logic [15:0]   pwm_on, pwm_off;
    logic [191:0]  pwm_high, pwm_low;
    logic [7:0]    prescale;
    logic          sleep, busy;

    int pass_cnt = 0;
    int total    = 0;

    pwm_update_sequencer dut (
        .clk_i               (clk),
        .rst_i               (rst),
        .register_blob_i     (blob),
        .write_enable_i      (we),
        .write_register_id_i (id),
        .counter_i           (cnt),
        .pwm_on_o            (pwm_on),
        .pwm_off_o           (pwm_off),
        .pwm_high_o          (pwm_high),
        .pwm_low_o           (pwm_low),
        .prescale_o          (prescale),
        .sleep_o             (sleep),
        .busy_o              (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [191:0] obs,
                       input logic [191:0] exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_byte(input logic [7:0] a, input logic [7:0] v);
        int k;
        k = int'(a);
        blob[k*8 +: 8] = v;
    endtask

    // Strobe sampled at one edge; the image shows the value afterwards.
    task automatic wr(input logic [7:0] a, input logic [7:0] v);
        @(negedge clk);
        we = 1'b1;
        id = a;
        @(posedge clk);
        #1;
        we = 1'b0;
        set_byte(a, v);
    endtask

    // Drive the counter through FFF -> 000 once, then hold it.
    task automatic run_wrap();
        @(negedge clk);
        cnt = 12'hFFD;
        repeat (4) begin
            @(negedge clk);
            cnt = cnt + 12'd1;
        end
        idle(1);
    endtask

    initial begin
        rst  = 1'b1;
        blob = '0;
        we   = 1'b0;
        id   = 8'h00;
        cnt  = 12'h100;

        // Reset state
        idle(3);
        chk("rst_off",   192'(pwm_off),  192'hFFFF);
        chk("rst_on",    192'(pwm_on),   192'h0);
        chk("rst_high",  pwm_high,       192'h0);
        chk("rst_low",   pwm_low,        192'h0);
        chk("rst_pre",   192'(prescale), 192'h1E);
        chk("rst_sleep", 192'(sleep),    192'h1);
        chk("rst_busy",  192'(busy),     192'h0);

        set_byte(8'h00, 8'h01);
        @(negedge clk);
        rst = 1'b0;
        idle(3);
        chk("awake_sleep", 192'(sleep),  192'h0);
        chk("awake_busy",  192'(busy),   192'h0);
        chk("awake_off",   192'(pwm_off), 192'hFFFF);

        // Channel 3: ON=0x000, OFF=0x199
        wr(8'h12, 8'h00);
        wr(8'h13, 8'h00);
        wr(8'h14, 8'h99);
        wr(8'h15, 8'h01);
        idle(2);
        chk("ch3_busy", 192'(busy), 192'h1);
        idle(10);
        chk("ch3_pre_low", pwm_low,       192'h0);
        chk("ch3_pre_off", 192'(pwm_off), 192'hFFFF);
        run_wrap();
        chk("ch3_low",  pwm_low,       192'h199 << 36);
        chk("ch3_off",  192'(pwm_off), 192'hFFF7);
        chk("ch3_on",   192'(pwm_on),  192'h0);
        chk("ch3_high", pwm_high,      192'h0);
        chk("ch3_idle", 192'(busy),    192'h0);

        // ALL_LED ON_H=0x10 (mirrored into every LEDn_ON_H), then ch5 OFF_L
        wr(8'hFB, 8'h10);
        for (int n = 0; n < 16; n++) set_byte(8'(8'h07 + 4 * n), 8'h10);
        wr(8'h1C, 8'h20);
        idle(10);
        chk("all_pre_on", 192'(pwm_on), 192'h0);
        run_wrap();
        chk("all_on",   192'(pwm_on),  192'hFFFF);
        chk("all_off",  192'(pwm_off), 192'h0);
        chk("all_high", pwm_high,      192'h0);
        chk("all_low",  pwm_low,       192'h020 << 60);

        // Prescale ignored while awake
        wr(8'hFE, 8'h79);
        idle(3);
        chk("pre_awake", 192'(prescale), 192'h1E);
        // Sleep, then prescale accepted
        wr(8'h00, 8'h11);
        idle(2);
        chk("sleep_on", 192'(sleep), 192'h1);
        wr(8'hFE, 8'h79);
        idle(2);
        chk("pre_sleep", 192'(prescale), 192'h79);
        // While asleep, commits need no wrap: ch1 OFF_H=0x10
        wr(8'h0D, 8'h10);
        idle(8);
        chk("sleep_commit", 192'(pwm_off), 192'h0002);
        chk("sleep_busy",   192'(busy),    192'h0);
        wr(8'h00, 8'h01);
        idle(2);
        chk("wake", 192'(sleep), 192'h0);

        // Dirty all channels, reset mid-staging
        for (int n = 0; n < 16; n++) wr(8'(8'h06 + 4 * n), 8'(n + 1));
        chk("mid_busy", 192'(busy), 192'h1);
        @(negedge clk);
        rst = 1'b1;
        idle(1);
        chk("mrst_on",    192'(pwm_on),   192'h0);
        chk("mrst_off",   192'(pwm_off),  192'hFFFF);
        chk("mrst_high",  pwm_high,       192'h0);
        chk("mrst_low",   pwm_low,        192'h0);
        chk("mrst_pre",   192'(prescale), 192'h1E);
        chk("mrst_sleep", 192'(sleep),    192'h1);
        chk("mrst_busy",  192'(busy),     192'h0);
        @(negedge clk);
        rst = 1'b0;
        idle(20);
        run_wrap();
        chk("post_off",  192'(pwm_off), 192'hFFFF);
        chk("post_on",   192'(pwm_on),  192'h0);
        chk("post_high", pwm_high,      192'h0);
        chk("post_busy", 192'(busy),    192'h0);

        // Re-write ch0 on the edge it is being staged
        wr(8'h06, 8'hAA);
        idle(1);
        wr(8'h06, 8'h55);
        idle(1);
        chk("rw_busy", 192'(busy), 192'h1);
        idle(10);
        chk("rw_pre_high", pwm_high, 192'h0);
        run_wrap();
        chk("rw_high", pwm_high,      192'h055);
        chk("rw_on",   192'(pwm_on),  192'h0001);
        chk("rw_off",  192'(pwm_off), 192'hFFFE);
        chk("rw_low",  pwm_low,       192'h0);
        chk("rw_busy_end", 192'(busy), 192'h0);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
